// File: rtl/dff_r.sv
// dff_r: positive-edge D flip-flop with synchronous, active-low reset.
// Leaf storage cell; WIDTH > 1 gives a vector of flops sharing clk/reset_n.
`timescale 1ns/1ps

module dff_r #(
    parameter int unsigned     WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on each rising edge; a low reset_n at that edge wins over d.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_dff_r.sv
// tb_dff_r: directed + randomized bench for dff_r, one single-bit flop with the
// default reset value and one 8-bit flop with a non-zero reset value.
`timescale 1ns/100ps

module tb_dff_r;

    localparam int unsigned WW   = 8;
    localparam logic [WW-1:0] WRST = 8'hA5;

    logic          clk;
    logic          reset_n;
    logic          d;
    logic          q;
    logic [WW-1:0] d_w;
    logic [WW-1:0] q_w;

    int checks = 0;
    int errors = 0;

    dff_r u_bit (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d),
        .q       (q)
    );

    dff_r #(.WIDTH(WW), .RESET_VALUE(WRST)) u_vec (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d_w),
        .q       (q_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Reference: after every edge, q is the reset value if reset_n was low at that
    // edge, otherwise the d seen at that edge; it must hold that until the next edge.
    logic          exp_q;
    logic [WW-1:0] exp_w;
    initial begin
        forever begin
            @(posedge clk);
            exp_q = reset_n ? d : 1'b0;
            exp_w = reset_n ? d_w : WRST;
            #1;
            check("model_bit_after_edge", WW'(q), WW'(exp_q));
            check("model_vec_after_edge", q_w, exp_w);
            #8;
            check("model_bit_before_edge", WW'(q), WW'(exp_q));
            check("model_vec_before_edge", q_w, exp_w);
        end
    end

    // Hand-computed expectations at fixed times of the directed sequence.
    initial begin
        #6;   check("lit_reset_dominance", WW'(q), WW'(1'b0));
              check("lit_vec_reset_value", q_w, WRST);
        #10;  check("lit_release_loads_d", WW'(q), WW'(1'b0));            // 16
              check("lit_vec_release_loads_d", q_w, 8'h3C);
        #8;   check("lit_not_before_edge", WW'(q), WW'(1'b0));            // 24
        #2;   check("lit_toggle_first", WW'(q), WW'(1'b1));               // 26
        #10;  check("lit_toggle_second", WW'(q), WW'(1'b0));              // 36
        #10;  check("lit_toggle_third", WW'(q), WW'(1'b1));               // 46
        #70;  check("lit_hold_first", WW'(q), WW'(1'b0));                 // 116
        #10;  check("lit_hold_second", WW'(q), WW'(1'b0));                // 126
        #8;   check("lit_vec_no_async_reset", q_w, 8'hC3);                // 134
        #2;   check("lit_sync_reset_135", WW'(q), WW'(1'b0));             // 136
              check("lit_vec_sync_reset", q_w, WRST);
        #10;  check("lit_sync_reset_145", WW'(q), WW'(1'b0));             // 146
        #10;  check("lit_sync_reset_155", WW'(q), WW'(1'b0));             // 156
        #20;  check("lit_glitch_immunity", WW'(q), WW'(1'b0));            // 176
    end

    // Stimulus: directed sequence, then randomized cycles with occasional glitches.
    initial begin
        reset_n = 1'b0;
        d       = 1'b0;
        d_w     = 8'h00;
        #3.3  d = 1'b1; d_w = 8'hFF;                       // 3.3
        #10   reset_n = 1'b1; d = 1'b0; d_w = 8'h3C;       // 13.3
        for (int k = 0; k < 9; k++) begin                  // 23.3 .. 103.3
            #10 d = ~k[0]; d_w = k[0] ? 8'h3C : 8'hC3;
        end
        #10   d = 1'b0;                                    // 113.3
        #20   reset_n = 1'b0; d = 1'b1; d_w = 8'h5A;       // 133.3
        #10   d = 1'b0;                                    // 143.3
        #10   d = 1'b1;                                    // 153.3
        #10   reset_n = 1'b1; d = 1'b0; d_w = 8'h00;       // 163.3
        #2.7  d = 1'b1;                                    // 166
        #2    d = 1'b0;                                    // 168

        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #3.3;
            reset_n = ($urandom_range(7) != 0);
            d       = 1'($urandom);
            d_w     = WW'($urandom);
            if ($urandom_range(3) == 0) begin
                #2.5 d = ~d; d_w = ~d_w;
                #1.5 d = ~d; d_w = ~d_w;
            end
        end
        @(posedge clk);
        #9.5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
